// File: rtl/mem_access_seq.sv
// Multicycle load/store sequencer between the datapath and word-wide memory.
// Sub-word stores use read-modify-write through the external ls/ss size units.
module mem_access_seq #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mdr_out,
  output logic [1:0]  ls_control,
  output logic [1:0]  ss_control,
  output logic [31:0] reg_b,
  input  logic [31:0] ls_result,
  input  logic [31:0] ss_result
);

  typedef enum logic [2:0] {IDLE, RD, EXT, WR, DONE} state_t;

  localparam logic [3:0] LAT = 4'(READ_LATENCY);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] b_q;
  logic [31:0] mdr;
  logic [2:0]  op_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      b_q       <= '0;
      mdr       <= '0;
      op_q      <= '0;
      load_data <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_wr    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q <= addr;
            op_q   <= op;
            b_q    <= store_data;
            busy   <= 1'b1;
            if (op[1:0] == 2'b11) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (op[2] && op[1:0] == 2'b10) begin
              // Full-word store overwrites everything, so no read is needed
              state  <= WR;
              mem_wr <= 1'b1;
            end else begin
              state <= RD;
              cnt   <= LAT;
            end
          end
        end
        RD: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            mdr <= mem_rdata;
            if (op_q[2]) begin
              state  <= WR;
              mem_wr <= 1'b1;
            end else begin
              state <= EXT;
            end
          end
        end
        EXT: begin
          load_data <= ls_result;
          state     <= DONE;
          done      <= 1'b1;
        end
        WR: begin
          mem_wr <= 1'b0;
          state  <= DONE;
          done   <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_wr <= 1'b0;
        end
      endcase
    end
  end

  // Write data is forced to zero outside WR so the bus is quiet when idle
  assign mem_wdata  = mem_wr ? ss_result : '0;
  assign mem_addr   = addr_q;
  assign mdr_out    = mdr;
  assign reg_b      = b_q;
  assign ls_control = op_q[1:0];
  assign ss_control = op_q[1:0];

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: one instance at READ_LATENCY=1, one at 3,
// each with a small word memory and behavioural ls/ss size units.
module tb_mem_access_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start3;
  logic [2:0]  op;
  logic [31:0] addr, store_data;

  logic        busy, done, err, mem_wr;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata, mdr_out, reg_b, ls_res, ss_res;
  logic [1:0]  ls_ctl, ss_ctl;

  logic        busy3, done3, err3, mem_wr3;
  logic [31:0] load_data3, mem_addr3, mem_wdata3, mem_rdata3, mdr_out3, reg_b3, ls_res3, ss_res3;
  logic [1:0]  ls_ctl3, ss_ctl3;

  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] ls_f(input logic [1:0] c, input logic [31:0] m);
    case (c)
      2'b00:   return {24'h0, m[7:0]};
      2'b01:   return {16'h0, m[15:0]};
      default: return m;
    endcase
  endfunction

  function automatic logic [31:0] ss_f(input logic [1:0] c, input logic [31:0] b, input logic [31:0] m);
    case (c)
      2'b00:   return {m[31:8], b[7:0]};
      2'b01:   return {m[31:16], b[15:0]};
      default: return b;
    endcase
  endfunction

  assign ls_res     = ls_f(ls_ctl, mdr_out);
  assign ss_res     = ss_f(ss_ctl, reg_b, mdr_out);
  assign ls_res3    = ls_f(ls_ctl3, mdr_out3);
  assign ss_res3    = ss_f(ss_ctl3, reg_b3, mdr_out3);
  assign mem_rdata  = mem1[mem_addr[7:2]];
  assign mem_rdata3 = mem3[mem_addr3[7:2]];

  // Memories reload their preset words on reset
  always @(posedge clk) begin
    if (rst) begin
      mem1[16] <= 32'hAABBCCDD;
      mem1[17] <= 32'h0;
      mem1[18] <= 32'h11223344;
      mem3[16] <= 32'hAABBCCDD;
    end else begin
      if (mem_wr)  mem1[mem_addr[7:2]]  <= mem_wdata;
      if (mem_wr3) mem3[mem_addr3[7:2]] <= mem_wdata3;
    end
  end

  mem_access_seq #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(rst), .start(start), .op(op), .addr(addr), .store_data(store_data),
    .busy(busy), .done(done), .err(err), .load_data(load_data), .mem_addr(mem_addr),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mdr_out(mdr_out),
    .ls_control(ls_ctl), .ss_control(ss_ctl), .reg_b(reg_b),
    .ls_result(ls_res), .ss_result(ss_res)
  );

  mem_access_seq #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(rst), .start(start3), .op(op), .addr(addr), .store_data(store_data),
    .busy(busy3), .done(done3), .err(err3), .load_data(load_data3), .mem_addr(mem_addr3),
    .mem_wr(mem_wr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .mdr_out(mdr_out3),
    .ls_control(ls_ctl3), .ss_control(ss_ctl3), .reg_b(reg_b3),
    .ls_result(ls_res3), .ss_result(ss_res3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start3 = 1'b0; op = 3'b000; addr = '0; store_data = '0;
    step(); step();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mdr", mdr_out, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_ls_ctl", 32'(ls_ctl), 32'd0);
    check("rst_ss_ctl", 32'(ss_ctl), 32'd0);

    // load byte at 0x40
    op = 3'b000; addr = 32'h40; start = 1'b1;
    step(); start = 1'b0;
    check("lb_t1_busy", 32'(busy), 32'd1);
    check("lb_t1_wr", 32'(mem_wr), 32'd0);
    check("lb_t1_addr", mem_addr, 32'h40);
    step();
    check("lb_t2_done", 32'(done), 32'd0);
    check("lb_t2_wr", 32'(mem_wr), 32'd0);
    step();
    check("lb_t3_done", 32'(done), 32'd1);
    check("lb_t3_err", 32'(err), 32'd0);
    check("lb_t3_data", load_data, 32'h000000DD);
    check("lb_t3_mdr", mdr_out, 32'hAABBCCDD);
    step();
    check("lb_t4_busy", 32'(busy), 32'd0);
    check("lb_t4_done", 32'(done), 32'd0);

    // store byte at 0x40
    op = 3'b100; addr = 32'h40; store_data = 32'h12345678; start = 1'b1;
    step(); start = 1'b0;
    check("sb_t1_wr", 32'(mem_wr), 32'd0);
    step();
    check("sb_t2_wr", 32'(mem_wr), 32'd1);
    check("sb_t2_wdata", mem_wdata, 32'hAABBCC78);
    check("sb_t2_addr", mem_addr, 32'h40);
    step();
    check("sb_t3_done", 32'(done), 32'd1);
    check("sb_t3_wr", 32'(mem_wr), 32'd0);
    check("sb_t3_ld_keep", load_data, 32'h000000DD);
    check("sb_mem", mem1[16], 32'hAABBCC78);
    step();

    // load halfword at 0x40
    op = 3'b001; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    check("lh_done", 32'(done), 32'd1);
    check("lh_data", load_data, 32'h0000CC78);
    step();

    // store word at 0x44
    op = 3'b110; addr = 32'h44; store_data = 32'hFFFFFFFF; start = 1'b1;
    step(); start = 1'b0;
    check("sw_t1_wr", 32'(mem_wr), 32'd1);
    check("sw_t1_wdata", mem_wdata, 32'hFFFFFFFF);
    check("sw_t1_addr", mem_addr, 32'h44);
    step();
    check("sw_t2_done", 32'(done), 32'd1);
    check("sw_t2_wr", 32'(mem_wr), 32'd0);
    check("sw_ld_keep", load_data, 32'h0000CC78);
    check("sw_mdr_keep", mdr_out, 32'hAABBCC78);
    check("sw_mem", mem1[17], 32'hFFFFFFFF);
    step();

    // illegal size
    op = 3'b011; addr = 32'h40; start = 1'b1;
    step(); start = 1'b0;
    check("il_t1_done", 32'(done), 32'd1);
    check("il_t1_err", 32'(err), 32'd1);
    check("il_t1_wr", 32'(mem_wr), 32'd0);
    step();
    check("il_t2_busy", 32'(busy), 32'd0);
    check("il_t2_err", 32'(err), 32'd0);
    check("il_t2_wr", 32'(mem_wr), 32'd0);
    check("il_mdr_keep", mdr_out, 32'hAABBCC78);
    check("il_ld_keep", load_data, 32'h0000CC78);

    // latency 3 instance: store halfword at 0x40 with an ignored start at T+2
    op = 3'b101; addr = 32'h40; store_data = 32'h12345678; start3 = 1'b1;
    step(); start3 = 1'b0;
    check("l3_t1_busy", 32'(busy3), 32'd1);
    check("l3_t1_wr", 32'(mem_wr3), 32'd0);
    step(); start3 = 1'b1;
    check("l3_t2_wr", 32'(mem_wr3), 32'd0);
    step(); start3 = 1'b0;
    check("l3_t3_wr", 32'(mem_wr3), 32'd0);
    check("l3_t3_busy", 32'(busy3), 32'd1);
    step();
    check("l3_t4_wr", 32'(mem_wr3), 32'd1);
    check("l3_t4_wdata", mem_wdata3, 32'hAABB5678);
    check("l3_t4_mdr", mdr_out3, 32'hAABBCCDD);
    step();
    check("l3_t5_done", 32'(done3), 32'd1);
    check("l3_t5_wr", 32'(mem_wr3), 32'd0);
    step();
    check("l3_t6_busy", 32'(busy3), 32'd0);
    step();
    check("l3_t7_busy", 32'(busy3), 32'd0);
    check("l3_mem", mem3[16], 32'hAABB5678);

    // reset while in WR
    op = 3'b100; addr = 32'h48; store_data = 32'h12345678; start = 1'b1;
    step(); start = 1'b0;
    step();
    check("rw_wr", 32'(mem_wr), 32'd1);
    check("rw_wdata", mem_wdata, 32'h11223378);
    rst = 1'b1;
    step(); rst = 1'b0;
    check("rw_mem_wr", 32'(mem_wr), 32'd0);
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_done", 32'(done), 32'd0);
    check("rw_mem_addr", mem_addr, 32'h0);
    check("rw_wdata0", mem_wdata, 32'h0);
    check("rw_mdr", mdr_out, 32'h0);
    check("rw_ld", load_data, 32'h0);
    check("rw_ctl", 32'(ls_ctl), 32'd0);
    check("rw_regb", reg_b, 32'h0);
    step();
    check("rw_done_later", 32'(done), 32'd0);

    // load word after reset completes normally
    op = 3'b010; addr = 32'h40; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    check("lw_done", 32'(done), 32'd1);
    check("lw_data", load_data, 32'hAABBCCDD);
    step();

    // reset and start together: request dropped
    rst = 1'b1; op = 3'b010; start = 1'b1;
    step(); rst = 1'b0; start = 1'b0;
    check("rs_busy", 32'(busy), 32'd0);
    step();
    check("rs_busy2", 32'(busy), 32'd0);
    check("rs_done", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Multicycle load/store sequencer sitting between the datapath and the word-wide memory. It is directly upstream of the `ls` and `ss` size units:
- drives their control inputs and the MDR word;
- consumes their results to return load data or write merged store words.

Sub-word stores are handled as read-modify-write. Word stores skip the read. Each access completes with a one-cycle `done` pulse.

## Interface
Parameters:
- READ_LATENCY, 1, cycles from `mem_addr` valid (read) to `mem_rdata` valid; legal range 1..15

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request strobe; sampled only in IDLE
- op  in  3  {is_store, size[1:0]}; size 00 byte, 01 halfword, 10 word, 11 illegal
- addr  in  32  access address, passed to memory unchanged
- store_data  in  32  register B value for stores
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with `done`, for illegal size
- load_data  out  32  last completed load result, held until next load completes
- mem_addr  out  32  memory address
- mem_wr  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- mdr_out  out  32  MDR register, to `ls`/`ss` RegMDROut
- ls_control  out  2  to `ls` LSControl
- ss_control  out  2  to `ss` RegSSControl
- ls_result  in  32  from `ls` LSControlOut
- ss_result  in  32  from `ss` SSControlOut

## Operation
- States:
  - IDLE, RD, EXT, WR, DONE
  - 4-bit latency counter
  - registers addr_q, op_q, b_q, mdr, load_data
- IDLE, start=1:
  - latch addr into addr_q, op into op_q, store_data into b_q.
  - Next state:
    - size 11 → DONE with err flag set;
    - store word → WR;
    - anything else → RD, with counter = READ_LATENCY.
- IDLE, start=0: stay.
- RD:
  - mem_addr=addr_q, mem_wr=0, counter decrements each cycle.
  - On the edge where counter==1: mdr←mem_rdata.
  - Next state: load → EXT; store → WR.
- EXT: at end of cycle, load_data←ls_result; then → DONE.
- WR: mem_wr=1, mem_addr=addr_q, mem_wdata=ss_result; then → DONE.
  - `ss` receives RegBOut = b_q, RegMDROut = mdr, control = op_q[1:0].
  - Merge semantics: byte replaces bits 7:0, halfword replaces bits 15:0, word replaces all.
- DONE:
  - done=1; err=1 only if op_q size was 11.
  - Next state: IDLE unconditionally.
  - start during DONE is ignored.
- Continuous outputs:
  - ls_control = ss_control = op_q[1:0].
  - mdr_out = mdr.
  - mem_addr = addr_q in all states.
  - mem_wdata = ss_result, meaningful only when mem_wr=1.
- start while busy=1 is ignored; no queuing.
- Stores never modify load_data. Illegal ops perform no memory access and leave mdr and load_data unchanged.

## Timing
Request sampled at edge T (state IDLE, start=1); L = READ_LATENCY.
- Load, any legal size:
  - RD cycles T+1..T+L
  - EXT T+L+1
  - DONE T+L+2, with load_data already valid
- Store byte/halfword:
  - RD T+1..T+L
  - WR T+L+1
  - DONE T+L+2
- Store word: WR T+1, DONE T+2, no read issued.
- Illegal size: DONE T+1 with err=1, mem_wr never asserted.
- Earliest next start accepted: the cycle after DONE, since IDLE is reached at T+L+3.
- Reset values:
  - state IDLE
  - busy, done, err, mem_wr = 0
  - mem_addr, mem_wdata, mdr_out, load_data = 0
  - ls_control, ss_control = 00
  - counter 0
- Reset mid-operation, any state: IDLE after that edge.
  - no done pulse;
  - mem_wr low from the following cycle;
  - all registers return to reset values.
- reset and start in the same cycle: reset wins, request dropped.

## Test plan
- Memory model with L=1, word[0x40]=0xAABBCCDD; load byte (op=000) at 0x40:
  - mem_wr stays 0
  - done at T+3
  - load_data=0x000000DD
  - err=0
- Store byte (op=100) at 0x40 with store_data=0x12345678:
  - one read at T+1
  - mem_wr=1 at T+2 with mem_wdata=0xAABBCC78
  - done at T+3
  - then load halfword (op=001) → load_data=0x0000CC78
- Store word (op=110) at 0x44, store_data=0xFFFFFFFF:
  - mem_wr=1 at T+1, mem_wdata=0xFFFFFFFF
  - done at T+2
  - load_data unchanged
- Illegal op=011:
  - done=err=1 at T+1
  - busy low at T+2
  - no mem_wr
  - mdr_out unchanged
- READ_LATENCY=3, store halfword at 0x40 (word 0xAABBCCDD, store_data 0x12345678):
  - RD T+1..T+3
  - mem_wr at T+4 with 0xAABB5678
  - done at T+5
  - a second start pulsed at T+2 is ignored
- reset asserted during WR:
  - next cycle mem_wr=0, busy=0, done never pulses
  - all outputs at reset values
  - a subsequent load completes normally
